// File: rtl/gelato_types_pkg.sv
// ---------------------------------------------------------------------------
// gelato_types
//   Types and constants shared by the Gelato writeback path.
//   BANK_NUM   : number of register-file banks (selected by reg bits [4:3])
//   warp_num_t : warp index
//   reg_num_t  : architectural register index (32 registers)
//   bank_of()  : bank selected by a register number
// ---------------------------------------------------------------------------
package gelato_types;

   localparam int BANK_NUM = 4;
   localparam int BANK_W   = $clog2(BANK_NUM);
   localparam int WARP_NUM = 8;

   typedef logic [$clog2(WARP_NUM)-1:0] warp_num_t;
   typedef logic [4:0]                  reg_num_t;

   // Registers are interleaved across banks in groups of eight.
   function automatic logic [BANK_W-1:0] bank_of(input reg_num_t r);
      return r[4:3];
   endfunction

endpackage

// File: rtl/gelato_round_robin_arbiter.sv
// ---------------------------------------------------------------------------
// gelato_round_robin_arbiter
//   Round-robin arbiter for one register bank. The grant is combinational:
//   the first requester found searching upward (mod N) from the pointer.
//   When advance is high and something is granted, the pointer moves to
//   one past the winner, so the winner becomes lowest priority next time.
//
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset (pointer -> 0)
//   advance in  allow the pointer to move this cycle
//   req     in  [N] request vector
//   grant   out [N] one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module gelato_round_robin_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         advance,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] ptr_next;

   always_comb begin
      logic       found;
      int         idx;
      logic [PTR_W-1:0] idx_w;
      grant    = '0;
      ptr_next = ptr_reg;
      found    = 1'b0;
      idx      = 0;
      idx_w    = '0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr_reg) + i;
         if (idx >= N) begin
            idx = idx - N;
         end
         idx_w = PTR_W'(idx);
         if (!found && req[idx_w]) begin
            found        = 1'b1;
            grant[idx_w] = 1'b1;
            ptr_next     = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
         end
      end
      if (!advance) begin
         ptr_next = ptr_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/gelato_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// gelato_writeback_arbiter
//   Arbitrates NUM_SRC writeback requesters onto BANK_NUM register-file
//   banks. Each requester targets the bank given by reg bits [4:3]; each
//   bank independently grants one requester per cycle (round robin), and
//   the winner's warp/reg/data are registered onto that bank's write port.
//
//   clk           in  clock
//   rst_n         in  asynchronous active-low reset
//   rdy           in  global enable; low = no grants, state holds
//   src_valid     in  [NUM_SRC] requester valid
//   src_ready     out [NUM_SRC] combinational grant (transfer = valid & ready)
//   src_warp_num  in  [NUM_SRC] target warp
//   src_reg_num   in  [NUM_SRC] target register (bits [4:3] = bank)
//   src_data      in  [NUM_SRC][DATA_W] write data
//   wb_valid      out [BANK_NUM] registered bank write enable
//   wb_warp_num   out [BANK_NUM] registered warp
//   wb_reg_num    out [BANK_NUM] registered register number
//   wb_data       out [BANK_NUM][DATA_W] registered write data
//   conflict_cnt  out 16-bit saturating count of stall cycles
// ---------------------------------------------------------------------------
module gelato_writeback_arbiter
   import gelato_types::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rdy,
   input  logic [NUM_SRC-1:0]  src_valid,
   output logic [NUM_SRC-1:0]  src_ready,
   input  warp_num_t           src_warp_num [NUM_SRC],
   input  reg_num_t            src_reg_num  [NUM_SRC],
   input  logic [DATA_W-1:0]   src_data     [NUM_SRC],
   output logic [BANK_NUM-1:0] wb_valid,
   output warp_num_t           wb_warp_num  [BANK_NUM],
   output reg_num_t            wb_reg_num   [BANK_NUM],
   output logic [DATA_W-1:0]   wb_data      [BANK_NUM],
   output logic [15:0]         conflict_cnt
);

   logic [NUM_SRC-1:0] bank_req   [BANK_NUM];
   logic [NUM_SRC-1:0] bank_grant [BANK_NUM];
   logic [BANK_NUM-1:0] bank_hit;
   warp_num_t          sel_warp   [BANK_NUM];
   reg_num_t           sel_reg    [BANK_NUM];
   logic [DATA_W-1:0]  sel_data   [BANK_NUM];
   logic               stall;

   // Bank select: split the valid vector into one request vector per bank.
   always_comb begin
      for (int b = 0; b < BANK_NUM; b++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            bank_req[b][s] = src_valid[s] && (bank_of(src_reg_num[s]) == BANK_W'(b));
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < BANK_NUM; gi++) begin : g_bank
         gelato_round_robin_arbiter #(
            .N(NUM_SRC)
         ) u_rr (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (rdy),
            .req     (bank_req[gi]),
            .grant   (bank_grant[gi])
         );
      end
   endgenerate

   // One-hot muxes per bank; a requester can only win its own bank, so the
   // per-source ready is just the OR of that source's grant across banks.
   always_comb begin
      src_ready = '0;
      for (int b = 0; b < BANK_NUM; b++) begin
         bank_hit[b] = rdy && (bank_grant[b] != '0);
         sel_warp[b] = '0;
         sel_reg[b]  = '0;
         sel_data[b] = '0;
         for (int s = 0; s < NUM_SRC; s++) begin
            if (bank_grant[b][s]) begin
               sel_warp[b] = sel_warp[b] | src_warp_num[s];
               sel_reg[b]  = sel_reg[b]  | src_reg_num[s];
               sel_data[b] = sel_data[b] | src_data[s];
            end
            src_ready[s] = src_ready[s] | (rst_n && rdy && bank_grant[b][s]);
         end
      end
   end

   assign stall = rdy && ((src_valid & ~src_ready) != '0);

   // Writeback pipeline register. Address/data only load on a grant so the
   // bank ports stay quiet while wb_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid <= '0;
         for (int b = 0; b < BANK_NUM; b++) begin
            wb_warp_num[b] <= '0;
            wb_reg_num[b]  <= '0;
            wb_data[b]     <= '0;
         end
      end else begin
         wb_valid <= bank_hit;
         for (int b = 0; b < BANK_NUM; b++) begin
            if (bank_hit[b]) begin
               wb_warp_num[b] <= sel_warp[b];
               wb_reg_num[b]  <= sel_reg[b];
               wb_data[b]     <= sel_data[b];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
      end else if (stall && (conflict_cnt != 16'hFFFF)) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

endmodule
